motor_drive_pwm: RTL and testbench
==================================

// Module: motor_drive_pwm
// PURPOSE
//  Parametrised multi-channel H-bridge drive generator.
//  - Converts signed-magnitude speed commands into fwd/rev PWM pairs, one pair per channel.
//  - Duty updates are glitch-free: commands are sampled only at the PWM period boundary.
//  - Inserts dead time on every direction reversal; supports brake and coast modes.
//  - Sits between the speed/steering control loop and the motor driver pins.
// PARAMETERS
//  MAG_W     10  magnitude bits; PWM period = 2^MAG_W clk cycles
//  NUM_CH     2  number of motor channels
//  DEAD_CYC  16  clk cycles with both outputs low on reversal; 0 = none; must be < 2^MAG_W
// PORTS
//  clk       in   1                  system clock
//  rst_n     in   1                  asynchronous active-low reset
//  en        in   1                  drive enable; 0 = coast all channels
//  cmd       in   NUM_CH*(MAG_W+1)   ch i = cmd[i*(MAG_W+1) +: MAG_W+1]
//                                    bit MAG_W = sign (1 = reverse), low MAG_W bits = magnitude
//  fwd       out  NUM_CH             forward drive, registered
//  rev       out  NUM_CH             reverse drive, registered
//  dead      out  NUM_CH             1 while channel is in DEAD state
//  prd_strt  out  1                  1-cycle pulse on the cycle where cnt == 0
// BEHAVIOUR
//  Reset: cnt=0; all duty/dir latches 0; last_dir_vld=0; all channels COAST.
//   All outputs 0 during and after reset until the FSM changes state.
//  Period counter:
//   - Shared MAG_W-bit up-counter; wraps 2^MAG_W-1 -> 0.
//   - Boundary = cycle where cnt == 2^MAG_W-1.
//  Sampling:
//   - At boundary, each channel latches sign and magnitude from cmd.
//   - Latched values take effect from cnt == 0.
//   - cmd changes mid-period are ignored until the next boundary.
//  PWM:
//   - drv = (cnt < duty_q); high for duty cycles out of 2^MAG_W.
//   - Max magnitude gives 2^MAG_W-1 high cycles.
//   - Outputs are flops: value at cycle t+1 reflects cnt/state at cycle t.
//  Per-channel FSM, states COAST, BRAKE, FWD, REV, DEAD; transitions evaluated at boundary unless noted.
//   - COAST: fwd=0, rev=0.
//   - BRAKE: fwd=1, rev=1.
//   - FWD:   fwd=drv, rev=0.
//   - REV:   fwd=0,   rev=drv.
//   - DEAD:  fwd=0,   rev=0, dead=1.
//   - en==0 (any cycle): next state COAST; dead counter cleared. Takes priority over all else.
//   - en==1 at boundary, magnitude 0: go to BRAKE. last_dir unchanged.
//   - en==1 at boundary, magnitude !=0: target = FWD/REV from sign.
//     If last_dir_vld and sign != last_dir: go to DEAD, load dead counter with DEAD_CYC.
//     Otherwise go directly to target.
//     In both cases last_dir <= sign and last_dir_vld <= 1.
//   - Reversal rule holds through BRAKE/COAST: FWD -> BRAKE -> REV still passes DEAD.
//   - DEAD: counts DEAD_CYC cycles, then enters the state given by the currently latched cmd, mid-period.
//     Entering FWD/REV this way resumes PWM against the current cnt.
//   - Boundary during DEAD: latch new cmd; dead counter is NOT restarted.
//     If the new sign differs again, last_dir is updated; DEAD ends on its original count.
//   - DEAD_CYC == 0: DEAD is bypassed.
//   - Same state and direction with a new magnitude: duty change only, no dead time.
//  Reset mid-operation (including mid-DEAD): immediate return to reset values; all outputs 0.
//  Channels are fully independent apart from the shared counter and en.
//  Invariant: fwd[i] & ~rev[i] and rev[i] & ~fwd[i] never occur on consecutive cycles without passing DEAD when direction flips.
// STRUCTURE
//  package motor_pkg:
//   - FSM state enum: COAST, BRAKE, FWD, REV, DEAD.
//   - Sign encoding constants: SGN_FWD = 0, SGN_REV = 1.
//   - Width helper function for the dead counter.
//  Sub-module motor_pwm_ch:
//   - One channel: cmd latch, FSM, dead counter, compare and output flops.
//  Top-level:
//   - Shared period counter and prd_strt generation.
//   - Generate loop over NUM_CH instances of motor_pwm_ch.
// TESTING (defaults unless stated)
//  1. en=1, ch0 cmd=+256, ch1 cmd=-100, no prior drive
//     -> after first boundary: fwd[0] high 256 of every 1024 cycles, rev[0]=0;
//        rev[1] high 100 of 1024 cycles, fwd[1]=0; no DEAD.
//  2. ch0 +512 changed to 0 mid-period
//     -> unchanged until wrap, then fwd[0]=rev[0]=1 continuously.
//  3. ch0 +512 -> -512
//     -> at boundary: fwd[0]=rev[0]=0 and dead[0]=1 for exactly 16 cycles,
//        then rev[0]=drv against the current cnt.
//     Also: +512 -> 0 -> -512 -> same 16-cycle DEAD.
//  4. DEAD_CYC=0, +300 -> -300
//     -> rev[0] PWM starts at cnt==0, dead[0] never set.
//  5. en dropped while fwd[0]=1
//     -> next cycle all outputs 0.
//     rst_n low during DEAD -> outputs 0, dead 0, immediately.
//  6. cmd=+1023
//     -> fwd high 1023 of 1024 cycles.
//     prd_strt pulses once per 1024 cycles, aligned with cnt==0.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and helpers for the multi-channel H-bridge PWM drive.
package motor_pkg;

    typedef enum logic [2:0] {
        COAST = 3'd0,
        BRAKE = 3'd1,
        FWD   = 3'd2,
        REV   = 3'd3,
        DEAD  = 3'd4
    } state_e;

    localparam logic SGN_FWD = 1'b0;
    localparam logic SGN_REV = 1'b1;

    // Dead counter must hold DEAD_CYC; keep at least one bit when dead time is disabled.
    function automatic int unsigned dead_cnt_w(input int unsigned dead_cyc);
        return (dead_cyc == 32'd0) ? 32'd1 : 32'($clog2(dead_cyc + 32'd1));
    endfunction

endpackage

// File: rtl/motor_pwm_ch.sv
// One H-bridge channel: command latch, drive FSM, dead-time counter and output flops.
module motor_pwm_ch
    import motor_pkg::*;
#(
    parameter int unsigned MAG_W    = 10,
    parameter int unsigned DEAD_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             bnd_i,
    input  logic [MAG_W-1:0] cnt_i,
    input  logic [MAG_W:0]   cmd_i,
    output logic             fwd_o,
    output logic             rev_o,
    output logic             dead_o
);

    localparam int unsigned DW = dead_cnt_w(DEAD_CYC);

    state_e           state_q, state_d, tgt_c;
    logic [MAG_W-1:0] duty_q, duty_d;
    logic             sign_q, sign_d;
    logic             last_dir_q, last_dir_d;
    logic             last_vld_q, last_vld_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             fwd_q, fwd_d, rev_q, rev_d, dead_q, dead_d;
    logic             drv_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COAST;
            duty_q     <= '0;
            sign_q     <= SGN_FWD;
            last_dir_q <= SGN_FWD;
            last_vld_q <= 1'b0;
            dcnt_q     <= '0;
            fwd_q      <= 1'b0;
            rev_q      <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            sign_q     <= sign_d;
            last_dir_q <= last_dir_d;
            last_vld_q <= last_vld_d;
            dcnt_q     <= dcnt_d;
            fwd_q      <= fwd_d;
            rev_q      <= rev_d;
            dead_q     <= dead_d;
        end
    end

    assign drv_c = (cnt_i < duty_q);

    // Next state; outputs reflect the current state and are forced low the cycle after en drops.
    always_comb begin
        duty_d     = duty_q;
        sign_d     = sign_q;
        last_dir_d = last_dir_q;
        last_vld_d = last_vld_q;
        dcnt_d     = dcnt_q;
        state_d    = state_q;
        tgt_c      = COAST;
        fwd_d      = 1'b0;
        rev_d      = 1'b0;
        dead_d     = 1'b0;

        if (en_i) begin
            unique case (state_q)
                BRAKE: begin
                    fwd_d = 1'b1;
                    rev_d = 1'b1;
                end
                FWD:     fwd_d  = drv_c;
                REV:     rev_d  = drv_c;
                DEAD:    dead_d = 1'b1;
                default: ;
            endcase
        end

        if (bnd_i) begin
            duty_d = cmd_i[MAG_W-1:0];
            sign_d = cmd_i[MAG_W];
        end

        if (duty_d == '0) begin
            tgt_c = BRAKE;
        end else if (sign_d == SGN_REV) begin
            tgt_c = REV;
        end else begin
            tgt_c = FWD;
        end

        if (!en_i) begin
            state_d = COAST;
            dcnt_d  = '0;
        end else if (state_q == DEAD) begin
            // A boundary inside DEAD only refreshes the command; the countdown is not restarted.
            if (bnd_i && (duty_d != '0)) begin
                last_dir_d = sign_d;
                last_vld_d = 1'b1;
            end
            if (dcnt_q <= DW'(1)) begin
                state_d = tgt_c;
                dcnt_d  = '0;
            end else begin
                dcnt_d = dcnt_q - DW'(1);
            end
        end else if (bnd_i) begin
            if (duty_d == '0) begin
                state_d = BRAKE;
            end else begin
                if ((DEAD_CYC != 0) && last_vld_q && (sign_d != last_dir_q)) begin
                    state_d = DEAD;
                    dcnt_d  = DW'(DEAD_CYC);
                end else begin
                    state_d = tgt_c;
                end
                last_dir_d = sign_d;
                last_vld_d = 1'b1;
            end
        end
    end

    assign fwd_o  = fwd_q;
    assign rev_o  = rev_q;
    assign dead_o = dead_q;

endmodule

// File: rtl/motor_drive_pwm.sv
// Multi-channel H-bridge PWM drive: shared period counter plus one channel engine per motor.
module motor_drive_pwm
    import motor_pkg::*;
#(
    parameter int unsigned MAG_W    = 10,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DEAD_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_CH*(MAG_W+1)-1:0] cmd,
    output logic [NUM_CH-1:0]         fwd,
    output logic [NUM_CH-1:0]         rev,
    output logic [NUM_CH-1:0]         dead,
    output logic                      prd_strt
);

    logic [MAG_W-1:0] cnt_q, cnt_d;
    logic             prd_q, prd_d;
    logic             bnd_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            prd_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            prd_q <= prd_d;
        end
    end

    // Boundary is the last count of the period; prd_strt lands on the following cnt == 0.
    always_comb begin
        cnt_d = cnt_q + MAG_W'(1);
        bnd_c = (cnt_q == '1);
        prd_d = bnd_c;
    end

    assign prd_strt = prd_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        motor_pwm_ch #(
            .MAG_W    (MAG_W),
            .DEAD_CYC (DEAD_CYC)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en),
            .bnd_i  (bnd_c),
            .cnt_i  (cnt_q),
            .cmd_i  (cmd[i*(MAG_W+1) +: (MAG_W+1)]),
            .fwd_o  (fwd[i]),
            .rev_o  (rev[i]),
            .dead_o (dead[i])
        );
    end

endmodule

// File: tb/tb_motor_drive_pwm.sv
// Bench for motor_drive_pwm: two instances (16-cycle and zero dead time) checked against a behavioural model.
`timescale 1ns/1ps
module tb_motor_drive_pwm;

    localparam int MW   = 10;
    localparam int NC   = 2;
    localparam int PER  = 1 << MW;
    localparam int CW   = NC * (MW + 1);
    localparam int DC_A = 16;

    localparam int M_COAST = 0;
    localparam int M_BRAKE = 1;
    localparam int M_FWD   = 2;
    localparam int M_REV   = 3;
    localparam int M_DEAD  = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic [CW-1:0] cmd   = '0;

    logic [NC-1:0] fwd_a, rev_a, dead_a, fwd_b, rev_b, dead_b;
    logic          prd_a, prd_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    motor_drive_pwm #(.MAG_W(MW), .NUM_CH(NC), .DEAD_CYC(DC_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .cmd(cmd),
        .fwd(fwd_a), .rev(rev_a), .dead(dead_a), .prd_strt(prd_a)
    );

    motor_drive_pwm #(.MAG_W(MW), .NUM_CH(NC), .DEAD_CYC(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .cmd(cmd),
        .fwd(fwd_b), .rev(rev_b), .dead(dead_b), .prd_strt(prd_b)
    );

    always #5 clk = ~clk;

    // Model: per-channel mode plus the outputs it must present one cycle later.
    typedef struct packed {
        int   duty;
        int   mode;
        int   dleft;
        logic sign;
        logic ld;
        logic ldv;
        logic fwd;
        logic rev;
        logic dead;
    } mch_t;

    int   m_cnt;
    logic m_prd;
    mch_t m [2][NC];

    function automatic int target(int duty, logic sign);
        if (duty == 0) return M_BRAKE;
        return sign ? M_REV : M_FWD;
    endfunction

    function automatic mch_t step(mch_t s, int cnt, logic en_v, logic [CW-1:0] cv, int c, int dc);
        mch_t       n = s;
        logic [MW:0] f;
        logic       bnd;
        f   = cv[c*(MW+1) +: (MW+1)];
        bnd = (cnt == PER - 1);
        n.fwd  = en_v && (s.mode == M_BRAKE || (s.mode == M_FWD && cnt < s.duty));
        n.rev  = en_v && (s.mode == M_BRAKE || (s.mode == M_REV && cnt < s.duty));
        n.dead = en_v && (s.mode == M_DEAD);
        if (bnd) begin
            n.duty = int'(f[MW-1:0]);
            n.sign = f[MW];
        end
        if (!en_v) begin
            n.mode  = M_COAST;
            n.dleft = 0;
        end else if (s.mode == M_DEAD) begin
            if (bnd && n.duty != 0) begin
                n.ld  = n.sign;
                n.ldv = 1'b1;
            end
            n.dleft = s.dleft - 1;
            if (n.dleft <= 0) n.mode = target(n.duty, n.sign);
        end else if (bnd) begin
            if (n.duty == 0) begin
                n.mode = M_BRAKE;
            end else begin
                if (s.ldv && n.sign != s.ld && dc > 0) begin
                    n.mode  = M_DEAD;
                    n.dleft = dc;
                end else begin
                    n.mode = target(n.duty, n.sign);
                end
                n.ld  = n.sign;
                n.ldv = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_prd <= 1'b0;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < NC; c++)
                    m[k][c] <= '0;
        end else begin
            m_cnt <= (m_cnt + 1) % PER;
            m_prd <= (m_cnt == PER - 1);
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < NC; c++)
                    m[k][c] <= step(m[k][c], m_cnt, en, cmd, c, (k == 0) ? DC_A : 0);
        end
    end

    function automatic logic [NC-1:0] ev(int k, int which);
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++)
            v[c] = (which == 0) ? m[k][c].fwd : (which == 1) ? m[k][c].rev : m[k][c].dead;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // One clock: advance to the falling edge and compare every output against the model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        cmp("fwd_a",  32'(fwd_a),  32'(ev(0, 0)));
        cmp("rev_a",  32'(rev_a),  32'(ev(0, 1)));
        cmp("dead_a", 32'(dead_a), 32'(ev(0, 2)));
        cmp("prd_a",  32'(prd_a),  32'(m_prd));
        cmp("fwd_b",  32'(fwd_b),  32'(ev(1, 0)));
        cmp("rev_b",  32'(rev_b),  32'(ev(1, 1)));
        cmp("dead_b", 32'(dead_b), 32'(ev(1, 2)));
        cmp("prd_b",  32'(prd_b),  32'(m_prd));
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (m_cnt != v && n < 3 * PER) begin
            tick();
            n++;
        end
        cmp("wait_cnt", 32'(m_cnt), 32'(v));
    endtask

    task automatic set_cmd(input int c, input logic sgn, input int mag);
        cmd[c*(MW+1) +: (MW+1)] = {sgn, MW'(mag)};
    endtask

    int cf [2][NC];
    int cr [2][NC];
    int cd [2][NC];
    int cp [2];

    task automatic clr();
        for (int k = 0; k < 2; k++) begin
            cp[k] = 0;
            for (int c = 0; c < NC; c++) begin
                cf[k][c] = 0;
                cr[k][c] = 0;
                cd[k][c] = 0;
            end
        end
    endtask

    task automatic count(input int n);
        repeat (n) begin
            for (int c = 0; c < NC; c++) begin
                cf[0][c] += int'(fwd_a[c]);
                cr[0][c] += int'(rev_a[c]);
                cd[0][c] += int'(dead_a[c]);
                cf[1][c] += int'(fwd_b[c]);
                cr[1][c] += int'(rev_b[c]);
                cd[1][c] += int'(dead_b[c]);
            end
            cp[0] += int'(prd_a);
            cp[1] += int'(prd_b);
            tick();
        end
    endtask

    // Count the outputs produced by one full period, starting from the next boundary.
    task automatic count_period();
        wait_cnt(PER - 1);
        wait_cnt(1);
        clr();
        count(PER);
    endtask

    initial begin
        repeat (3) tick();
        cmp("rst_fwd_a", 32'(fwd_a), 32'd0);
        cmp("rst_rev_a", 32'(rev_a), 32'd0);
        cmp("rst_prd_a", 32'(prd_a), 32'd0);
        rst_n = 1'b1;
        tick();

        // Forward 256 on ch0, reverse 100 on ch1, no prior direction.
        en = 1'b1;
        set_cmd(0, 1'b0, 256);
        set_cmd(1, 1'b1, 100);
        count_period();
        cmp("t1_fwd0", 32'(cf[0][0]), 32'd256);
        cmp("t1_rev0", 32'(cr[0][0]), 32'd0);
        cmp("t1_rev1", 32'(cr[0][1]), 32'd100);
        cmp("t1_fwd1", 32'(cf[0][1]), 32'd0);
        cmp("t1_dead", 32'(cd[0][0] + cd[0][1]), 32'd0);
        cmp("t1_prd",  32'(cp[0]), 32'd1);

        // Mid-period change to 0 is ignored until the wrap, then brake.
        set_cmd(0, 1'b0, 512);
        wait_cnt(PER - 1);
        wait_cnt(1);
        clr();
        count(299);
        set_cmd(0, 1'b0, 0);
        count(PER - 299);
        cmp("t2_fwd0", 32'(cf[0][0]), 32'd512);
        cmp("t2_rev0", 32'(cr[0][0]), 32'd0);
        count_period();
        cmp("t2_brk_f", 32'(cf[0][0]), 32'd1024);
        cmp("t2_brk_r", 32'(cr[0][0]), 32'd1024);

        // Reversal through BRAKE still inserts dead time.
        set_cmd(0, 1'b1, 512);
        count_period();
        cmp("t3_dead_a", 32'(cd[0][0]), 32'd16);
        cmp("t3_rev_a",  32'(cr[0][0]), 32'd496);
        cmp("t3_fwd_a",  32'(cf[0][0]), 32'd0);
        cmp("t3_dead_b", 32'(cd[1][0]), 32'd0);
        cmp("t3_rev_b",  32'(cr[1][0]), 32'd512);

        set_cmd(0, 1'b0, 300);
        count_period();
        cmp("t4_dead_a", 32'(cd[0][0]), 32'd16);
        cmp("t4_fwd_a",  32'(cf[0][0]), 32'd284);
        cmp("t4_fwd_b",  32'(cf[1][0]), 32'd300);
        set_cmd(0, 1'b1, 300);
        count_period();
        cmp("t4r_rev_a",  32'(cr[0][0]), 32'd284);
        cmp("t4r_rev_b",  32'(cr[1][0]), 32'd300);
        cmp("t4r_dead_b", 32'(cd[1][0]), 32'd0);

        // +512 -> 0 -> -512 passes the same dead window.
        set_cmd(0, 1'b0, 512);
        count_period();
        set_cmd(0, 1'b0, 0);
        count_period();
        cmp("t3b_brk_dead", 32'(cd[0][0]), 32'd0);
        set_cmd(0, 1'b1, 512);
        count_period();
        cmp("t3b_dead_a", 32'(cd[0][0]), 32'd16);
        cmp("t3b_rev_a",  32'(cr[0][0]), 32'd496);
        cmp("t3b_rev_b",  32'(cr[1][0]), 32'd512);

        // Dropping en while driving forward clears outputs on the next cycle.
        set_cmd(0, 1'b0, 512);
        count_period();
        wait_cnt(100);
        cmp("t5_fwd_hi", 32'(fwd_a[0]), 32'd1);
        en = 1'b0;
        tick();
        cmp("t5_off_fa", 32'(fwd_a), 32'd0);
        cmp("t5_off_ra", 32'(rev_a), 32'd0);
        cmp("t5_off_fb", 32'(fwd_b), 32'd0);
        cmp("t5_off_rb", 32'(rev_b), 32'd0);

        // Asynchronous reset in the middle of a dead window.
        set_cmd(0, 1'b1, 512);
        en = 1'b1;
        wait_cnt(PER - 1);
        wait_cnt(5);
        cmp("t5_in_dead", 32'(dead_a[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("t5_rst_dead", 32'(dead_a), 32'd0);
        cmp("t5_rst_fwd",  32'(fwd_a),  32'd0);
        cmp("t5_rst_rev",  32'(rev_a),  32'd0);
        cmp("t5_rst_prd",  32'(prd_a),  32'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Near-full duty and period pulse spacing.
        set_cmd(0, 1'b0, 1023);
        count_period();
        cmp("t6_fwd",  32'(cf[0][0]), 32'd1023);
        cmp("t6_dead", 32'(cd[0][0]), 32'd0);
        clr();
        count(2 * PER);
        cmp("t6_fwd2", 32'(cf[0][0]), 32'd2046);
        cmp("t6_prd_a", 32'(cp[0]), 32'd2);
        cmp("t6_prd_b", 32'(cp[1]), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
